tristate_const_top: RTL and testbench

Single-bit tristate output driver with a clocked activity monitor. While `en` is high the block actively drives `b` with the complement of `a`. While `en` is low it releases `b` to high impedance. The driver path is purely combinational and never depends on the clock. A clocked side channel counts drive windows and records the last driven value, giving the surrounding logic status visibility.

---
 rtl/tristate_const_top.sv | 72 +++++++
 tb/tb_tristate_const_top.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tristate_const_top.sv
`timescale 1ns/1ps
// tristate_const_top: inverting single-bit tristate driver with a clocked
// side-channel monitor that counts drive windows and records the last value
// driven. The driver path is purely combinational; clk and rst_n only touch
// the monitor.
module tristate_const_top #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             a,
    output logic             b,
    output logic [CNT_W-1:0] drive_cnt,
    output logic             last_drv,
    output logic             active
);

    logic syncMeta;
    logic activePrev;
    logic windowRise;
    logic cntAtMax;

    // Driver: a single conditional keeps b = ~a the moment en rises, floats b
    // when en is low, and yields x on b for an unknown enable.
    assign b = en ? ~a : 1'bz;

    // Two-flop synchronizer for the asynchronous enable; active is the second stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncMeta <= 1'b0;
            active   <= 1'b0;
        end else begin
            syncMeta <= en;
            active   <= syncMeta;
        end
    end

    // Edge-detect register holding the previous synchronized enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            activePrev <= 1'b0;
        end else begin
            activePrev <= active;
        end
    end

    // New drive window when synchronized enable goes 0 -> 1; counter stops at all-ones.
    always_comb begin
        windowRise = active & ~activePrev;
        cntAtMax   = (drive_cnt == '1);
    end

    // Saturating drive-window counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drive_cnt <= '0;
        end else if (windowRise && !cntAtMax) begin
            drive_cnt <= drive_cnt + CNT_W'(1);
        end
    end

    // Status copy of the driven value; a is sampled raw since this is informational only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_drv <= 1'b0;
        end else if (active) begin
            last_drv <= ~a;
        end
    end

endmodule

// File: tb/tb_tristate_const_top.sv
`timescale 1ns/1ps
// tb_tristate_const_top: directed stimulus with a queue-based scoreboard.
// Stimulus pushes expected values; a separate monitor drains and compares.
module tb_tristate_const_top;

    localparam int K_B      = 0;  // b driven value
    localparam int K_BZ     = 1;  // b released (1 = is z)
    localparam int K_CNT    = 2;  // drive_cnt of main instance
    localparam int K_LAST   = 3;  // last_drv of main instance
    localparam int K_ACT    = 4;  // active of main instance
    localparam int K_SATCNT = 5;  // drive_cnt of CNT_W=4 instance
    localparam int K_BS     = 6;  // b of CNT_W=4 instance

    logic        clk = 1'b0;
    logic        clkRun = 1'b0;
    logic        rst_n, en, a;
    wire         b;
    logic [15:0] drive_cnt;
    logic        last_drv, active;

    logic        rstS_n, enS, aS;
    wire         bS;
    logic [3:0]  satCnt;
    logic        lastS, activeS;

    tristate_const_top #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b),
        .drive_cnt(drive_cnt), .last_drv(last_drv), .active(active)
    );

    tristate_const_top #(.CNT_W(4)) dutSat (
        .clk(clk), .rst_n(rstS_n), .en(enS), .a(aS), .b(bS),
        .drive_cnt(satCnt), .last_drv(lastS), .active(activeS)
    );

    // Gated clock so the driver can be exercised with clk held still.
    initial forever begin
        #5;
        if (clkRun) clk = ~clk;
    end

    int          kindQ[$];
    logic [15:0] expQ[$];
    string       nameQ[$];
    logic        chkReq = 1'b0;
    int          nTests = 0;
    int          nFail = 0;

    task automatic expectV(input int k, input logic [15:0] v, input string nm);
        kindQ.push_back(k);
        expQ.push_back(v);
        nameQ.push_back(nm);
    endtask

    task automatic fire();
        chkReq = ~chkReq;
        #0.1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: whenever stimulus presents a check request, drain the scoreboard.
    always @(chkReq) begin
        int          k;
        logic [15:0] e;
        logic [15:0] act;
        string       nm;
        while (kindQ.size() != 0) begin
            k  = kindQ.pop_front();
            e  = expQ.pop_front();
            nm = nameQ.pop_front();
            case (k)
                K_B:      act = {15'b0, b};
                K_BZ:     act = {15'b0, (b === 1'bz)};
                K_CNT:    act = drive_cnt;
                K_LAST:   act = {15'b0, last_drv};
                K_ACT:    act = {15'b0, active};
                K_SATCNT: act = {12'b0, satCnt};
                default:  act = {15'b0, bS};
            endcase
            nTests++;
            if (act !== e) begin
                nFail++;
                $display("FAIL %s: got %0h expected %0h at %0t", nm, act, e, $time);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic aLast;

    initial begin
        rst_n = 1'b0; en = 1'b0; a = 1'b0;
        rstS_n = 1'b0; enS = 1'b0; aS = 1'b0;
        #2;

        // Reset state of both monitors
        expectV(K_CNT, 16'd0, "rst_cnt");
        expectV(K_LAST, 16'd0, "rst_last");
        expectV(K_ACT, 16'd0, "rst_active");
        expectV(K_SATCNT, 16'd0, "rst_satcnt");
        fire();

        // Tristate release with clk held: b floats for both values of a
        en = 1'b0; a = 1'b0; #1;
        expectV(K_BZ, 16'd1, "release_a0");
        fire();
        a = 1'b1; #1;
        expectV(K_BZ, 16'd1, "release_a1");
        fire();

        // Drive invert with clk held and monitor in reset
        en = 1'b1; a = 1'b0; #1;
        expectV(K_B, 16'd1, "drive_a0");
        fire();
        a = 1'b1; #1;
        expectV(K_B, 16'd0, "drive_a1");
        fire();
        en = 1'b0; #1;
        expectV(K_BZ, 16'd1, "release_after_drive");
        fire();

        // Async race: a every 3ns, en every 5ns; check b at each en rise
        fork
            begin
                for (int i = 0; i < 6667; i++) begin #3; a = ~a; end
            end
            begin
                #1;
                for (int i = 0; i < 4000; i++) begin #5; en = ~en; end
            end
            begin
                for (int i = 0; i < 2000; i++) begin
                    @(posedge en);
                    #0.5;
                    expectV(K_B, {15'b0, ~a}, "race_b_inv");
                    fire();
                end
            end
        join
        en = 1'b0; a = 1'b0;

        // Counter: reset, then 10 four-clock pulses
        clkRun = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        for (int i = 0; i < 10; i++) begin
            aLast = (i % 3 == 1);
            a = aLast; en = 1'b1; #1;
            expectV(K_B, {15'b0, ~aLast}, "cnt_b_drive");
            fire();
            tick(1);
            expectV(K_ACT, 16'd0, "act_edge1");
            fire();
            tick(1);
            expectV(K_ACT, 16'd1, "act_edge2");
            expectV(K_CNT, 16'(i), "cnt_before_detect");
            fire();
            tick(1);
            expectV(K_CNT, 16'(i + 1), "cnt_after_detect");
            expectV(K_LAST, {15'b0, ~aLast}, "last_in_window");
            fire();
            tick(1);
            en = 1'b0; #1;
            expectV(K_BZ, 16'd1, "cnt_b_release");
            fire();
            tick(1);
            expectV(K_ACT, 16'd1, "act_fall_edge1");
            fire();
            tick(1);
            expectV(K_ACT, 16'd0, "act_fall_edge2");
            fire();
            tick(2);
        end
        expectV(K_CNT, 16'd10, "cnt_total");
        expectV(K_LAST, {15'b0, ~aLast}, "last_final");
        fire();
        a = aLast ? 1'b0 : 1'b1;
        tick(3);
        expectV(K_LAST, {15'b0, ~aLast}, "last_holds");
        fire();

        // Saturation on the CNT_W=4 instance: 20 pulses stop at 15
        rstS_n = 1'b1;
        tick(1);
        for (int i = 0; i < 20; i++) begin
            aS = i[0]; enS = 1'b1; #1;
            expectV(K_BS, {15'b0, ~aS}, "sat_b_drive");
            fire();
            tick(3);
            enS = 1'b0;
            tick(3);
            expectV(K_SATCNT, (i + 1 > 15) ? 16'd15 : 16'(i + 1), "sat_cnt");
            fire();
        end

        // Reset mid-window with drive_cnt = 3
        rst_n = 1'b0; #1;
        rst_n = 1'b1;
        tick(1);
        for (int i = 0; i < 2; i++) begin
            en = 1'b1; tick(4);
            en = 1'b0; tick(4);
        end
        a = 1'b1; en = 1'b1;
        tick(4);
        expectV(K_CNT, 16'd3, "mid_cnt3");
        expectV(K_ACT, 16'd1, "mid_active");
        fire();
        #1 rst_n = 1'b0; #1;
        expectV(K_CNT, 16'd0, "mid_rst_cnt");
        expectV(K_ACT, 16'd0, "mid_rst_active");
        expectV(K_LAST, 16'd0, "mid_rst_last");
        expectV(K_B, 16'd0, "mid_rst_b_a1");
        fire();
        a = 1'b0; #1;
        expectV(K_B, 16'd1, "mid_rst_b_a0");
        fire();
        @(posedge clk); #1;
        expectV(K_CNT, 16'd0, "rst_beats_clk");
        fire();
        rst_n = 1'b1;
        tick(1);
        expectV(K_ACT, 16'd0, "rel_edge1_active");
        fire();
        tick(1);
        expectV(K_ACT, 16'd1, "rel_edge2_active");
        expectV(K_CNT, 16'd0, "rel_edge2_cnt");
        fire();
        tick(1);
        expectV(K_CNT, 16'd1, "rel_edge3_cnt");
        fire();

        #1;
        if (kindQ.size() != 0) begin
            nFail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", kindQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
